// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller: ALU control
// codes, RV32I opcodes, branch funct3 values and the issue FSM states.
package alu_pkg;

  // ALU control codes driven to the external combinational ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;  // unsigned compare, result 1/0
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  // Supported RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Supported branch conditions
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU control
// code, operand-b select, branch flag and illegal flag. Illegal requests
// are forced to a neutral ADD with register operand so the top can zero them.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              use_imm,
  output logic              is_branch,
  output logic              illegal
);

  // Decode table; defaults first, illegal combinations neutralised at the end
  always_comb begin
    alu_ctrl  = CTRL_W'(ALU_ADD);
    use_imm   = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R, OP_I: begin
        use_imm = (opcode == OP_I);
        case (funct3)
          3'b000: alu_ctrl = (opcode == OP_R && funct7b5) ? CTRL_W'(ALU_SUB) : CTRL_W'(ALU_ADD);
          3'b111: alu_ctrl = CTRL_W'(ALU_AND);
          3'b110: alu_ctrl = CTRL_W'(ALU_OR);
          3'b100: alu_ctrl = CTRL_W'(ALU_XOR);
          3'b011: alu_ctrl = CTRL_W'(ALU_SLT);
          3'b001: alu_ctrl = CTRL_W'(ALU_SLL);
          3'b101: alu_ctrl = funct7b5 ? CTRL_W'(ALU_SRA) : CTRL_W'(ALU_SRL);
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        use_imm = 1'b1;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE:   alu_ctrl = CTRL_W'(ALU_SUB);
          F3_BLTU, F3_BGEU: alu_ctrl = CTRL_W'(ALU_SLT);
          default:          illegal  = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_ctrl  = CTRL_W'(ALU_ADD);
      use_imm   = 1'b0;
      is_branch = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue side of the ALU interface: accepts a decoded request, registers the
// control code and operands toward the external ALU, then captures the ALU
// result and branch outcome into a response register with valid/ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   imm,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_branch_taken,
  output logic              out_illegal
);

  state_e              state_q, state_d;
  logic                accept, capture;

  logic [CTRL_W-1:0]   dec_ctrl;
  logic                dec_use_imm, dec_is_branch, dec_illegal;

  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0]     alu_a_q, alu_a_d;
  logic [XLEN-1:0]     alu_b_q, alu_b_d;
  logic                is_branch_q, illegal_q;
  logic [2:0]          br_f3_q;
  logic [XLEN-1:0]     out_result_q, out_result_d;
  logic                out_branch_q, out_branch_d;
  logic                out_illegal_q;

  alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .alu_ctrl  (dec_ctrl),
    .use_imm   (dec_use_imm),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state and handshake outputs; in_ready is masked during reset
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset_n) in_ready = 1'b0;
  end

  assign accept = in_valid && in_ready;

  // Operand/control selection at acceptance and result/branch evaluation in EXEC
  always_comb begin
    alu_ctrl_d = dec_illegal ? CTRL_W'(ALU_ADD) : dec_ctrl;
    alu_a_d    = dec_illegal ? '0 : rs1_val;
    alu_b_d    = dec_illegal ? '0 : (dec_use_imm ? imm : rs2_val);
    out_result_d = illegal_q ? '0 : alu_result;
    out_branch_d = 1'b0;
    if (is_branch_q && !illegal_q) begin
      case (br_f3_q)
        F3_BEQ:  out_branch_d = alu_zero;
        F3_BNE:  out_branch_d = !alu_zero;
        F3_BLTU: out_branch_d = alu_result[0];
        F3_BGEU: out_branch_d = !alu_result[0];
        default: out_branch_d = 1'b0;
      endcase
    end
  end

  // Request registers load on acceptance; response registers load leaving EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_ctrl_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      is_branch_q   <= 1'b0;
      illegal_q     <= 1'b0;
      br_f3_q       <= 3'b000;
      out_result_q  <= '0;
      out_branch_q  <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_ctrl_q  <= alu_ctrl_d;
        alu_a_q     <= alu_a_d;
        alu_b_q     <= alu_b_d;
        is_branch_q <= dec_is_branch;
        illegal_q   <= dec_illegal;
        br_f3_q     <= funct3;
      end
      if (capture) begin
        out_result_q  <= out_result_d;
        out_branch_q  <= out_branch_d;
        out_illegal_q <= illegal_q;
      end
    end
  end

  assign alu_ctrl         = alu_ctrl_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign out_result       = out_result_q;
  assign out_branch_taken = out_branch_q;
  assign out_illegal      = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_branch_taken, out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_ctrl #(.XLEN(32), .CTRL_W(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .opcode           (opcode),
    .funct3           (funct3),
    .funct7b5         (funct7b5),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .imm              (imm),
    .alu_ctrl         (alu_ctrl),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  always #5 clk = ~clk;

  // External combinational ALU model
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1000: alu_result = alu_a << alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode = op; funct3 = f3; funct7b5 = f7;
    rs1_val = a; rs2_val = b; imm = im;
  endtask

  // One full transaction, called one time unit after a rising edge with the DUT idle
  task automatic do_op(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [3:0] e_ctrl, input logic [31:0] e_a, input logic [31:0] e_b,
                       input logic [31:0] e_res, input logic e_br, input logic e_ill);
    set_req(op, f3, f7, a, b, im);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(e_ctrl));
    check({tag, ".alu_a"}, alu_a, e_a);
    check({tag, ".alu_b"}, alu_b, e_b);
    check({tag, ".exec_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, out_result, e_res);
    check({tag, ".branch"}, 32'(out_branch_taken), 32'(e_br));
    check({tag, ".illegal"}, 32'(out_illegal), 32'(e_ill));
    @(posedge clk); #1;
    check({tag, ".retired"}, 32'(out_valid), 32'd0);
    $display("op %-10s ctrl=%b a=%08h b=%08h result=%08h br=%0d ill=%0d",
             tag, alu_ctrl, alu_a, alu_b, out_result, out_branch_taken, out_illegal);
  endtask

  // Issue with out_ready low and stop after the given number of edges (1=EXEC, 2=RESP)
  task automatic start_hold(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input int edges);
    set_req(op, f3, 1'b0, a, b, 32'd0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (edges > 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    check({tag, ".alu_a"}, alu_a, 32'd0);
    check({tag, ".alu_b"}, alu_b, 32'd0);
    check({tag, ".result"}, out_result, 32'd0);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".branch"}, 32'(out_branch_taken), 32'd0);
    check({tag, ".illegal"}, 32'(out_illegal), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".post_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".post_valid2"}, 32'(out_valid), 32'd0);
    $display("reset %s done", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    set_req(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst.alu_a", alu_a, 32'd0);
    check("rst.result", out_result, 32'd0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk); #1;
    check("rst.idle_ready", 32'(in_ready), 32'd1);
    check("rst.idle_valid", 32'(out_valid), 32'd0);

    // tag, op, f3, f7, rs1, rs2, imm, ctrl, a, b, result, branch, illegal
    do_op("add",   7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    do_op("sub",   7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 4'b0001, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0);
    do_op("and",   7'b0110011, 3'b111, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 4'b0010, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0);
    do_op("or",    7'b0110011, 3'b110, 1'b0, 32'hF0F0, 32'h0F00, 32'd0, 4'b0011, 32'hF0F0, 32'h0F00, 32'hFFF0, 1'b0, 1'b0);
    do_op("xor",   7'b0110011, 3'b100, 1'b0, 32'hFF00, 32'h0FF0, 32'd0, 4'b0100, 32'hFF00, 32'h0FF0, 32'hF0F0, 1'b0, 1'b0);
    do_op("sltu",  7'b0110011, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0101, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    do_op("sll",   7'b0110011, 3'b001, 1'b0, 32'd1, 32'd4, 32'd0, 4'b1000, 32'd1, 32'd4, 32'd16, 1'b0, 1'b0);
    do_op("srai",  7'b0010011, 3'b101, 1'b1, 32'h80, 32'h55, 32'd4, 4'b0111, 32'h80, 32'd4, 32'h8, 1'b0, 1'b0);
    do_op("srai_n",7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h55, 32'd4, 4'b0111, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
    do_op("srli",  7'b0010011, 3'b101, 1'b0, 32'h80000000, 32'h55, 32'd4, 4'b0110, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0);
    do_op("addi",  7'b0010011, 3'b000, 1'b1, 32'd10, 32'd3, 32'hFFFFFFFF, 4'b0000, 32'd10, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0);
    do_op("load",  7'b0000011, 3'b010, 1'b0, 32'h100, 32'h999, 32'd8, 4'b0000, 32'h100, 32'd8, 32'h108, 1'b0, 1'b0);
    do_op("store", 7'b0100011, 3'b010, 1'b0, 32'h200, 32'h999, 32'hFFFFFFFC, 4'b0000, 32'h200, 32'hFFFFFFFC, 32'h1FC, 1'b0, 1'b0);
    do_op("beq_t", 7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'd0, 4'b0001, 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
    do_op("beq_n", 7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1235, 32'd0, 4'b0001, 32'h1234, 32'h1235, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("bne_t", 7'b1100011, 3'b001, 1'b0, 32'h1234, 32'h1235, 32'd0, 4'b0001, 32'h1234, 32'h1235, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_op("bltu_t",7'b1100011, 3'b110, 1'b0, 32'd3, 32'd5, 32'd0, 4'b0101, 32'd3, 32'd5, 32'd1, 1'b1, 1'b0);
    do_op("bgeu_n",7'b1100011, 3'b111, 1'b0, 32'd3, 32'd5, 32'd0, 4'b0101, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);
    do_op("bgeu_t",7'b1100011, 3'b111, 1'b0, 32'd5, 32'd3, 32'd0, 4'b0101, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);
    do_op("ill_op",7'b1110011, 3'b000, 1'b0, 32'h11, 32'h22, 32'h33, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    do_op("ill_r", 7'b0110011, 3'b010, 1'b0, 32'h11, 32'h22, 32'h33, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    do_op("ill_i", 7'b0010011, 3'b010, 1'b0, 32'h11, 32'h22, 32'h33, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    do_op("ill_br",7'b1100011, 3'b100, 1'b0, 32'd1, 32'd1, 32'd0, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Backpressure: hold the response for five cycles with a second request waiting
    start_hold(7'b0110011, 3'b000, 32'd100, 32'd23, 2);
    set_req(7'b0110011, 3'b000, 1'b1, 32'd50, 32'd8, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.result", out_result, 32'd123);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.alu_a", alu_a, 32'd100);
      $display("backpressure cycle %0d result=%0d in_ready=%0d", i, out_result, in_ready);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.next_valid", 32'(out_valid), 32'd0);
    check("bp.next_a", alu_a, 32'd50);
    check("bp.next_ctrl", 32'(alu_ctrl), 32'd1);
    @(posedge clk); #1;
    check("bp.next_resp", 32'(out_valid), 32'd1);
    check("bp.next_result", out_result, 32'd42);
    @(posedge clk); #1;
    $display("backpressure back-to-back result=%0d", out_result);

    // Reset mid-EXEC (previous response 42 still in the result register)
    start_hold(7'b0110011, 3'b000, 32'hABCD, 32'h1111, 1);
    check("rexec.pre_a", alu_a, 32'hABCD);
    pulse_reset("rexec");

    // Reset in RESP with a taken branch, then with an illegal op
    start_hold(7'b1100011, 3'b000, 32'h77, 32'h77, 2);
    check("rresp_br.pre_branch", 32'(out_branch_taken), 32'd1);
    pulse_reset("rresp_br");
    start_hold(7'b1110011, 3'b000, 32'h5, 32'h6, 2);
    check("rresp_ill.pre_illegal", 32'(out_illegal), 32'd1);
    pulse_reset("rresp_ill");

    do_op("post",  7'b0110011, 3'b000, 1'b0, 32'd20, 32'd22, 32'd0, 4'b0000, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
